// File: rtl/thor2021_fetch_align.sv
// Fetch-to-decoder alignment queue: folds EXI7/EXI23/EXI41 prefixes into the next instruction.
// One cycle from accept to ir_o; in_ready_o depends only on occupancy, never on out_ready_i.
module thor2021_fetch_align #(
  parameter int DEPTH = 4,
  parameter int AWID  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [47:0]              in_insn_i,
  input  logic [AWID-1:0]          in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [47:0]              ir_o,
  output logic [47:0]              xir_o,
  output logic [AWID-1:0]          pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0]  EXI7     = 8'h50;
  localparam logic [7:0]  EXI23    = 8'h51;
  localparam logic [7:0]  EXI41    = 8'h52;
  localparam logic [47:0] NOP_INSN = 48'h0000_0000_00F1;

  logic [47:0]     ir_mem  [DEPTH];
  logic [47:0]     xir_mem [DEPTH];
  logic [AWID-1:0] pc_mem  [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [47:0]     pfx;
  logic            pfx_v;
  logic [AWID-1:0] pc_hold;

  logic            accept;
  logic            pop;
  logic            push;
  logic            is_pfx;
  logic [7:0]      opcode;

  assign opcode = in_insn_i[7:0];
  assign is_pfx = (opcode == EXI7) || (opcode == EXI23) || (opcode == EXI41);

  assign in_ready_o  = rst_ni && (count_q < CW'(DEPTH));
  assign out_valid_o = (count_q != '0);

  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign pop    = out_valid_o && out_ready_i && !flush_i;
  assign push   = accept && !is_pfx;

  // Empty queue shows NOP and the last displayed pc, so the decoder never sees stale words.
  assign ir_o    = out_valid_o ? ir_mem[rd_ptr]  : NOP_INSN;
  assign xir_o   = out_valid_o ? xir_mem[rd_ptr] : NOP_INSN;
  assign pc_o    = out_valid_o ? pc_mem[rd_ptr]  : pc_hold;
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      ir_mem[wr_ptr]  <= in_insn_i;
      xir_mem[wr_ptr] <= pfx_v ? pfx : NOP_INSN;
      pc_mem[wr_ptr]  <= in_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Latest prefix wins; any accepted instruction word consumes the pending one.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pfx_v <= 1'b0;
      pfx   <= NOP_INSN;
    end else if (flush_i) begin
      pfx_v <= 1'b0;
    end else if (accept) begin
      if (is_pfx) begin
        pfx_v <= 1'b1;
        pfx   <= in_insn_i;
      end else begin
        pfx_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pc_hold <= '0;
    else         pc_hold <= pc_o;
  end

endmodule

// File: doc/thor2021_fetch_align.md
# thor2021_fetch_align

Instruction alignment queue between the instruction fetch unit and `Thor2021_decoder`. It accepts one fetched 48-bit instruction word per cycle and folds EXI7/EXI23/EXI41 constant-extension prefixes into the following instruction. It buffers the resulting {ir, xir, pc} triples in a small FIFO and presents them to the decoder with a valid/ready handshake.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `AWID`, 32: program counter width.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  synchronous reset, active-low.
- `flush_i`  in  1  branch/exception redirect; discards all queued and pending state.
- `in_valid_i`  in  1  fetch word present.
- `in_ready_o`  out  1  block accepts a word this cycle.
- `in_insn_i`  in  48  fetched instruction word (`Instruction` type); opcode in bits [7:0].
- `in_pc_i`  in  AWID  address of `in_insn_i`.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  decoder consumes the head entry.
- `ir_o`  out  48  instruction to the decoder's `ir`.
- `xir_o`  out  48  prefix to the decoder's `xir`, or NOP.
- `pc_o`  out  AWID  address of `ir_o`; the address of the instruction, not the prefix.
- `count_o`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Accept occurs when `in_valid_i && in_ready_o && !flush_i`. Pop occurs when `out_valid_o && out_ready_i && !flush_i`.
- Prefix detection: the opcode of the accepted word equals EXI7, EXI23 or EXI41 (package constants).
- Accepted prefix: stored in the pending-prefix register `pfx` with `pfx_v=1`; it occupies no queue slot.
- Prefix arriving while `pfx_v=1`: replaces `pfx` (latest wins). The older prefix is dropped silently.
- Accepted non-prefix word: enqueued as {ir=word, xir=(pfx_v ? pfx : NOP), pc=in_pc_i}. `pfx_v` clears on the same edge.
- NOP is the package NOP instruction constant. The decoder treats a NOP `xir` as "no extension".
- `in_ready_o = rst_ni && (count < DEPTH)`. It does not depend on `out_ready_i`, so there is no combinational path from the decoder to the fetch unit.
- Prefix words are also refused when the queue is full; this keeps fetch ordering simple.
- `out_valid_o = (count != 0)`. `ir_o`, `xir_o` and `pc_o` come directly from the head storage register. When empty, `ir_o` and `xir_o` are NOP and `pc_o` holds its last value.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any occupancy below DEPTH.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count saturates at neither end; overflow and underflow are prevented by the handshake.
- `flush_i`: on the next edge, count=0, both pointers=0 and `pfx_v=0`.
  - Flush overrides a simultaneous accept and pop; both are ignored.
  - The fetch unit re-presents from the redirected pc.
- No state machine beyond queue, pointers and prefix register. Prefix state is implicit: IDLE (`pfx_v=0`) ↔ PFX (`pfx_v=1`).

## Timing
- Reset (edge with `rst_ni=0`): count=0, pointers=0, `pfx_v=0`, `pc_o`=0. Consequently `out_valid_o=0` and `ir_o`/`xir_o`=NOP.
- `in_ready_o` is 0 for as long as `rst_ni=0`, and is 1 in the first cycle after reset deasserts.
- Latency: a non-prefix word accepted at edge N appears on `ir_o` with `out_valid_o=1` in the cycle after edge N.
- A prefixed pair needs two accepts, so it appears one cycle after the instruction word is accepted.
- Throughput: one instruction per cycle sustained, provided the decoder holds `out_ready_i=1`. Each prefix costs one input cycle.
- Outputs are stable while `out_valid_o && !out_ready_i`.
- Reset mid-operation discards everything, including a pending prefix. Reset has priority over `flush_i`.

## Test plan
- Reset, then 3 plain words (pc 0x100, 0x106, 0x10C) with `out_ready_i=1` → three outputs, each one cycle after acceptance, `xir_o`=NOP, pc_o matching.
- EXI23 prefix at 0x200 followed by ADDIL at 0x206 → single output with ir=ADDIL, xir=EXI23 word, pc_o=0x206, count peaks at 1.
- EXI7 then EXI41 then ORIL → one output with xir=EXI41 word; the EXI7 word never appears.
- `out_ready_i=0`, push 4 words → `in_ready_o=0` at count=4 and the 5th word is held. Release for one cycle → pop, `in_ready_o=1` next cycle, and ordering is preserved across pointer wrap.
- Prefix accepted, then `flush_i` in the same cycle as the instruction word → count=0, `out_valid_o=0`. The next plain word re-presented after the flush carries `xir_o`=NOP.
- `rst_ni` low for one edge with count=3 and `pfx_v=1` → count_o=0, `out_valid_o=0`, `in_ready_o=0` during reset, then 1 the cycle after release.
